// File: rtl/ddr_rx_crc5_engine.sv
// Serial CRC-5 engine for the HDR-DDR read path.
// Accumulates RX data bits on both SCL edges and shifts the CRC back MSB first.
module ddr_rx_crc5_engine #(
    parameter int unsigned CRC_W    = 5,
    parameter logic [4:0]  CRC_INIT = 5'h1F,
    parameter logic [4:0]  CRC_POLY = 5'h05,
    parameter int unsigned CNT_W    = 6
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_sclgen_scl_pos_edge,
    input  logic             i_sclgen_scl_neg_edge,
    input  logic             i_sdahnd_rx_sda,
    input  logic             i_rx_crc_en,
    input  logic             i_ddrccc_crc_clear,
    input  logic             i_rx_crc_chk,
    output logic             o_crc_value,
    output logic             o_crc_valid,
    output logic [CRC_W-1:0] o_crc_word,
    output logic [CNT_W-1:0] o_crc_bit_cnt,
    output logic             o_crc_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        HOLD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ptr_q, ptr_d;

    logic             scl_edge;
    logic             fb;
    logic [CRC_W-1:0] crc_next;
    logic [CNT_W-1:0] cnt_next;
    logic [CRC_W-1:0] crc_sh;

    assign scl_edge = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;

    // One LFSR step with the current SDA bit; counter saturates at all-ones.
    assign fb       = crc_q[CRC_W-1] ^ i_sdahnd_rx_sda;
    assign crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    assign cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (i_ddrccc_crc_clear) begin
            state_d = IDLE;
            crc_d   = CRC_INIT;
            cnt_d   = '0;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_rx_crc_en) begin
                        state_d = ACCUM;
                        if (scl_edge) begin
                            crc_d = crc_next;
                            cnt_d = cnt_next;
                        end
                    end else if (i_rx_crc_chk) begin
                        state_d = SHIFT;
                        ptr_d   = '0;
                    end
                end
                ACCUM: begin
                    if (!i_rx_crc_en) begin
                        state_d = HOLD;
                    end else if (scl_edge) begin
                        crc_d = crc_next;
                        cnt_d = cnt_next;
                    end
                end
                HOLD: begin
                    if (i_rx_crc_chk) begin
                        state_d = SHIFT;
                        ptr_d   = '0;
                    end else if (i_rx_crc_en) begin
                        // Next data word continues the running CRC.
                        state_d = ACCUM;
                        if (scl_edge) begin
                            crc_d = crc_next;
                            cnt_d = cnt_next;
                        end
                    end
                end
                SHIFT: begin
                    if (!i_rx_crc_chk) begin
                        state_d = HOLD;
                        ptr_d   = '0;
                    end else if (scl_edge) begin
                        if (ptr_q == 3'd4) begin
                            state_d = DONE;
                            ptr_d   = '0;
                        end else begin
                            ptr_d = ptr_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign crc_sh        = crc_q << ptr_q;
    assign o_crc_valid   = (state_q == SHIFT);
    assign o_crc_value   = o_crc_valid & crc_sh[CRC_W-1];
    assign o_crc_done    = (state_q == DONE);
    assign o_crc_word    = crc_q;
    assign o_crc_bit_cnt = cnt_q;

endmodule

// File: tb/tb_ddr_rx_crc5_engine.sv
// Directed self-checking bench for ddr_rx_crc5_engine.
module tb_ddr_rx_crc5_engine;

    logic       clk;
    logic       rst;
    logic       pos_e;
    logic       neg_e;
    logic       sda;
    logic       en;
    logic       clr;
    logic       chk;
    logic       crc_value;
    logic       crc_valid;
    logic [4:0] crc_word;
    logic [5:0] bit_cnt;
    logic       crc_done;

    int checks = 0;
    int errors = 0;

    ddr_rx_crc5_engine dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst),
        .i_sclgen_scl_pos_edge (pos_e),
        .i_sclgen_scl_neg_edge (neg_e),
        .i_sdahnd_rx_sda       (sda),
        .i_rx_crc_en           (en),
        .i_ddrccc_crc_clear    (clr),
        .i_rx_crc_chk          (chk),
        .o_crc_value           (crc_value),
        .o_crc_valid           (crc_valid),
        .o_crc_word            (crc_word),
        .o_crc_bit_cnt         (bit_cnt),
        .o_crc_done            (crc_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] crc_ref(input logic [31:0] d, input int n);
        logic [4:0] c;
        logic f;
        c = 5'h1F;
        for (int i = n - 1; i >= 0; i--) begin
            f = c[4] ^ d[i];
            c = {c[3:0], 1'b0} ^ (f ? 5'h05 : 5'h00);
        end
        return c;
    endfunction

    task automatic do_clear;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic edge_bit(input logic b, input logic use_neg);
        sda   = b;
        pos_e = ~use_neg;
        neg_e = use_neg;
        tick();
        pos_e = 1'b0;
        neg_e = 1'b0;
    endtask

    logic [31:0] data;
    logic [4:0]  model;
    logic [4:0]  shift_exp;

    initial begin
        rst = 1'b1; pos_e = 1'b0; neg_e = 1'b0; sda = 1'b0;
        en = 1'b0; clr = 1'b0; chk = 1'b0;
        tick(); tick();
        check("rst_word", crc_word, 5'h1F);
        check("rst_cnt", bit_cnt, 0);
        check("rst_valid", crc_valid, 0);
        check("rst_value", crc_value, 0);
        check("rst_done", crc_done, 0);
        rst = 1'b0;
        do_clear();
        check("clr_word", crc_word, 5'h1F);
        check("clr_cnt", bit_cnt, 0);

        // Edge in the IDLE->ACCUM cycle is accumulated.
        en = 1'b1;
        edge_bit(1'b1, 1'b0);
        check("one_bit1_word", crc_word, 5'h1E);
        check("one_bit1_cnt", bit_cnt, 1);
        en = 1'b0; tick();
        do_clear();
        en = 1'b1;
        edge_bit(1'b0, 1'b1);
        check("one_bit0_word", crc_word, 5'h1B);
        en = 1'b0; tick();

        // Two bits then serial readback of 5'h19.
        do_clear();
        en = 1'b1; tick();
        edge_bit(1'b1, 1'b0);
        edge_bit(1'b0, 1'b1);
        check("two_bit_word", crc_word, 5'h19);
        check("two_bit_cnt", bit_cnt, 2);
        en = 1'b0; tick();
        check("hold_valid", crc_valid, 0);
        chk = 1'b1; tick();
        shift_exp = 5'h19;
        for (int i = 0; i < 5; i++) begin
            check("shift_valid", crc_valid, 1);
            check("shift_value", crc_value, shift_exp[4-i]);
            check("shift_nodone", crc_done, 0);
            edge_bit(1'b0, i[0]);
        end
        check("done_pulse", crc_done, 1);
        check("done_valid", crc_valid, 0);
        chk = 1'b0; tick();
        check("done_once", crc_done, 0);
        check("done_frozen", crc_word, 5'h19);

        // Two 16-bit words vs one contiguous 32-bit run.
        data = 32'hA5C3_19E7;
        model = crc_ref(data, 32);
        do_clear();
        en = 1'b1; tick();
        for (int i = 31; i >= 16; i--) edge_bit(data[i], i[0]);
        en = 1'b0; tick(); tick();
        check("split_mid_cnt", bit_cnt, 16);
        check("split_mid_word", crc_word, crc_ref(data >> 16, 16));
        en = 1'b1; tick();
        for (int i = 15; i >= 0; i--) edge_bit(data[i], i[0]);
        en = 1'b0; tick();
        check("split_word", crc_word, model);
        check("split_cnt", bit_cnt, 32);
        do_clear();
        en = 1'b1; tick();
        for (int i = 31; i >= 0; i--) edge_bit(data[i], i[0]);
        en = 1'b0; tick();
        check("contig_word", crc_word, model);
        check("contig_cnt", bit_cnt, 32);

        // Both strobes in one cycle count once.
        do_clear();
        en = 1'b1; sda = 1'b1; pos_e = 1'b1; neg_e = 1'b1;
        tick();
        pos_e = 1'b0; neg_e = 1'b0;
        check("both_edge_word", crc_word, 5'h1E);
        check("both_edge_cnt", bit_cnt, 1);
        en = 1'b0; tick();

        // Falling en coincident with an edge drops that bit.
        do_clear();
        en = 1'b1; tick();
        edge_bit(1'b1, 1'b0);
        en = 1'b0;
        edge_bit(1'b0, 1'b0);
        check("en_fall_word", crc_word, 5'h1E);
        check("en_fall_cnt", bit_cnt, 1);

        // Counter saturation.
        do_clear();
        en = 1'b1; tick();
        for (int i = 0; i < 70; i++) edge_bit(i[1], i[0]);
        check("sat_cnt", bit_cnt, 63);
        en = 1'b0; tick();

        // Clear coincident with an edge mid-ACCUM.
        do_clear();
        en = 1'b1; tick();
        edge_bit(1'b1, 1'b0);
        edge_bit(1'b1, 1'b1);
        clr = 1'b1;
        edge_bit(1'b1, 1'b0);
        clr = 1'b0; en = 1'b0;
        check("clr_edge_word", crc_word, 5'h1F);
        check("clr_edge_cnt", bit_cnt, 0);
        check("clr_edge_valid", crc_valid, 0);

        // Zero data bits: check right after clear shifts out 5'h1F.
        do_clear();
        chk = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            check("zero_value", crc_value, 1);
            edge_bit(1'b0, i[0]);
        end
        check("zero_done", crc_done, 1);
        chk = 1'b0; tick();

        // Early chk drop restarts from the MSB.
        do_clear();
        en = 1'b1;
        edge_bit(1'b0, 1'b0);
        en = 1'b0; tick();
        chk = 1'b1; tick();
        edge_bit(1'b0, 1'b0);
        edge_bit(1'b0, 1'b1);
        check("early_ptr2_value", crc_value, 1'b0);
        chk = 1'b0; tick();
        check("early_drop_valid", crc_valid, 0);
        chk = 1'b1; tick();
        check("restart_msb", crc_value, 1'b1);

        // Reset mid-SHIFT.
        edge_bit(1'b0, 1'b0);
        check("pre_rst_valid", crc_valid, 1);
        rst = 1'b1; chk = 1'b0;
        tick();
        check("rst_shift_word", crc_word, 5'h1F);
        check("rst_shift_cnt", bit_cnt, 0);
        check("rst_shift_valid", crc_valid, 0);
        check("rst_shift_done", crc_done, 0);
        rst = 1'b0; tick();
        check("rst_shift_nodone", crc_done, 0);
        check("rst_shift_value", crc_value, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
